// File: rtl/gray_stream_checker.sv
// gray_stream_checker
// Decodes a stream of Gray-coded words to binary and flags any accepted word
// that is not exactly one bit away from the previously accepted word. Results
// are queued in a 2-entry in-order FIFO with valid/ready on both sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no reference word yet; next accepted word is stored unchecked
// TRACK | reference held in prev_q; every accepted word is step-checked
module gray_stream_checker #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_gray,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_err,
    input  logic             out_ready,
    output logic [7:0]       err_count,
    output logic             locked
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH:0]   head_q, tail_q;   // {bin, err}
    logic [1:0]       occ_q;
    logic [7:0]       cnt_q;

    logic             accept, pop;
    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] diff;
    logic             step_ok;
    logic             word_err;
    logic [WIDTH:0]   new_word;

    assign in_ready  = rst_n & ~clear & (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        dec_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_bin[i] = ^(in_gray >> i);
        end
    end

    // Legal step means exactly one bit differs: non-zero and a power of two
    always_comb begin
        diff    = in_gray ^ prev_q;
        step_ok = (diff != '0) &&
                  ((diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    end

    // Next-state and error flag for the word being accepted this cycle
    always_comb begin
        state_d  = state_q;
        word_err = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = TRACK;
            if (state_q == TRACK) begin
                word_err = ~step_ok;
            end
        end
    end

    assign new_word = {dec_bin, word_err};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reference word: updated on every accept, legal or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (clear) begin
            prev_q <= '0;
        end else if (accept) begin
            prev_q <= in_gray;
        end
    end

    // Two-entry FIFO; accept+pop can only coincide at occupancy 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else if (clear) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b11: begin
                    head_q <= new_word;
                end
                2'b01: begin
                    head_q <= tail_q;
                    tail_q <= '0;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= new_word;
                    end else begin
                        tail_q <= new_word;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (accept && word_err && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign out_bin   = out_valid ? head_q[WIDTH:1] : '0;
    assign out_err   = out_valid & head_q[0];
    assign err_count = cnt_q;
    assign locked    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_stream_checker.sv
// Directed bench for gray_stream_checker (WIDTH = 4).
module tb_gray_stream_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_gray = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_bin;
    logic         out_err;
    logic         out_ready = 1'b0;
    logic [7:0]   err_count;
    logic         locked;

    int n_cmp  = 0;
    int n_miss = 0;

    gray_stream_checker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .out_ready (out_ready),
        .err_count (err_count),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] g;
        logic         ordy;
        logic         clr;
        logic         e_rdy;
        logic         e_ov;
        logic [W-1:0] e_bin;
        logic         e_err;
        logic [7:0]   e_cnt;
        logic         e_lock;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [15:0] observe();
        return {in_ready, out_valid, out_bin, out_err, err_count, locked};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] g, input logic ordy, input logic clr);
        in_valid  = v;
        in_gray   = g;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] to_gray(input int i);
        logic [W-1:0] b;
        b = W'(i);
        return b ^ (b >> 1);
    endfunction

    initial begin
        // {v, g, ordy, clr | rdy, ov, bin, err, cnt, lock}; checks are of state before the edge
        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 8'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 8'd1, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd1, 1'b1};
        tbl[4]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 8'd1, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 8'd0, 1'b1};
        tbl[7]  = '{1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 8'd0, 1'b1};
        tbl[8]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 8'd0, 1'b1};
        tbl[9]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 8'd0, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 8'd0, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 8'd0, 1'b1};
        tbl[12] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0, 1'b1};
        tbl[13] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 8'd1, 1'b1};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 8'd1, 1'b1};
        tbl[15] = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd1, 1'b1};
        tbl[16] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 8'd1, 1'b1};
        tbl[17] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  1'b0, 8'd1, 1'b1};
        tbl[18] = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0, 1'b0};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 8'd0, 1'b1};

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_outputs", 32'(observe()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_idle", 32'(observe()), 32'(16'b1_0_0000_0_00000000_0));

        // Full Gray cycle 0..15 then wrap to 0, consumer always ready
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, to_gray(i % 16), 1'b1, 1'b0);
            #1;
            if (i == 0) begin
                chk("seq_first_empty", 32'({out_valid, locked}), 32'b00);
            end else begin
                chk($sformatf("seq_word%0d", i - 1),
                    32'({out_valid, out_bin, out_err, err_count, locked}),
                    32'({1'b1, 4'((i - 1) % 16), 1'b0, 8'd0, 1'b1}));
            end
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("seq_wrap_to_zero", 32'({out_valid, out_bin, out_err, err_count}),
            32'({1'b1, 4'd0, 1'b0, 8'd0}));
        step();

        drive(1'b0, '0, 1'b0, 1'b1);
        step();

        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].v, tbl[k].g, tbl[k].ordy, tbl[k].clr);
            #1;
            chk($sformatf("vec%0d", k), 32'(observe()),
                32'({tbl[k].e_rdy, tbl[k].e_ov, tbl[k].e_bin, tbl[k].e_err,
                     tbl[k].e_cnt, tbl[k].e_lock}));
            step();
        end

        // Repeated word: error on second, saturation at 255 after 300+ repeats
        drive(1'b0, '0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 302; i++) begin
            drive(1'b1, 4'b0001, 1'b1, 1'b0);
            #1;
            if (i == 1) chk("repeat_first_ok", 32'({out_valid, out_bin, out_err}), 32'({1'b1, 4'd1, 1'b0}));
            if (i == 2) chk("repeat_second_err", 32'({out_valid, out_bin, out_err, err_count}),
                            32'({1'b1, 4'd1, 1'b1, 8'd1}));
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("err_count_saturated", 32'({err_count, out_err}), 32'({8'd255, 1'b1}));
        step();

        // Asynchronous reset with a full FIFO
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        #1;
        chk("full_before_reset", 32'({in_ready, out_valid, locked}), 32'b011);
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 32'(observe()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0011, 1'b1, 1'b0);
        #1;
        chk("after_reset_empty", 32'({in_ready, out_valid, locked}), 32'b100);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("after_reset_unchecked", 32'({out_valid, out_bin, out_err, err_count, locked}),
            32'({1'b1, 4'd2, 1'b0, 8'd0, 1'b1}));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
